// File: rtl/game_tick_scheduler_pkg.sv
// Shared definitions for the game frame sequencer: state encoding, default
// speed-scaling constants and the ball divisor rule.
package game_tick_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_PADDLE,
    ST_BALL,
    ST_COLLIDE,
    ST_FRAME_END
  } sched_state_e;

  localparam int unsigned DEF_LVL_W     = 3;
  localparam int unsigned DEF_MAX_LEVEL = 7;
  localparam int unsigned DEF_BALL_DIV0 = 8;
  localparam int unsigned DEF_TIMEOUT   = 1023;

  // Ticks per ball step at a given level, never below one.
  function automatic int unsigned ball_div(input int unsigned div0, input int unsigned lvl);
    return (div0 > lvl + 1) ? (div0 - lvl) : 1;
  endfunction

  function automatic logic is_step(input sched_state_e s);
    return (s == ST_PADDLE) || (s == ST_BALL) || (s == ST_COLLIDE);
  endfunction

endpackage

// File: rtl/game_tick_scheduler_phase_handshake.sv
// Shared strobe/done handshake for one engine phase: strobe on the first
// cycle of the phase, then wait for done or force completion on timeout.
module phase_handshake
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic enter_i,
  input  logic active_i,
  input  logic done_i,
  output logic step_o,
  output logic complete_o,
  output logic timeout_o
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;

  always_comb begin
    hit        = (cnt_q == CW'(TIMEOUT));
    step_o     = active_i & first_q;
    complete_o = active_i & (done_i | hit);
    timeout_o  = active_i & hit & ~done_i;
    first_d    = enter_i;
    cnt_d      = cnt_q;
    if (enter_i) begin
      cnt_d = '0;
    end else if (active_i && !complete_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame sequencer: one paddle/ball/collision update frame per accepted game
// tick, with level-scaled ball stepping, one-deep tick queue and sticky flags.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned BALL_DIV0 = DEF_BALL_DIV0,
  parameter int unsigned MAX_LEVEL = DEF_MAX_LEVEL,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned LVL_W     = DEF_LVL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             pause,
  input  logic             speed_up,
  input  logic             speed_reset,
  output logic             paddle_step,
  input  logic             paddle_done,
  output logic             ball_step,
  input  logic             ball_done,
  output logic             collide_step,
  input  logic             collide_done,
  output logic             frame_done,
  output logic [LVL_W-1:0] level,
  output logic             overrun,
  output logic             fault
);

  localparam int unsigned CNT_W = (BALL_DIV0 < 2) ? 1 : $clog2(BALL_DIV0);

  sched_state_e     state_q, state_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             fault_q, fault_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] ball_cnt_q, ball_cnt_d;

  logic hs_enter, hs_active, hs_done, hs_step, hs_complete, hs_timeout;
  logic ball_fire;

  phase_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_handshake (
    .clock     (clock),
    .reset     (reset),
    .enter_i   (hs_enter),
    .active_i  (hs_active),
    .done_i    (hs_done),
    .step_o    (hs_step),
    .complete_o(hs_complete),
    .timeout_o (hs_timeout)
  );

  always_comb begin
    hs_active = is_step(state_q);
    unique case (state_q)
      ST_PADDLE:  hs_done = paddle_done;
      ST_BALL:    hs_done = ball_done;
      ST_COLLIDE: hs_done = collide_done;
      default:    hs_done = 1'b0;
    endcase
    // Uses the level in the cycle the paddle phase ends; >= keeps the
    // counter from running past a divisor that just shrank.
    ball_fire = (32'(ball_cnt_q) + 32'd1) >= ball_div(BALL_DIV0, 32'(level_q));
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    fault_d    = fault_q | hs_timeout;
    level_d    = level_q;
    ball_cnt_d = ball_cnt_q;

    if (speed_reset) begin
      level_d = '0;
    end else if (speed_up && (level_q < LVL_W'(MAX_LEVEL))) begin
      level_d = level_q + 1'b1;
    end

    if (tick && !pause && (state_q != ST_WAIT_TICK)) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (!pause && (tick || pending_q)) begin
          pending_d = 1'b0;
          state_d   = ST_PADDLE;
        end
      end
      ST_PADDLE: begin
        if (hs_complete) begin
          if (ball_fire) begin
            ball_cnt_d = '0;
            state_d    = ST_BALL;
          end else begin
            ball_cnt_d = ball_cnt_q + 1'b1;
            state_d    = ST_FRAME_END;
          end
        end
      end
      ST_BALL: begin
        if (hs_complete) state_d = ST_COLLIDE;
      end
      ST_COLLIDE: begin
        if (hs_complete) state_d = ST_FRAME_END;
      end
      ST_FRAME_END: begin
        state_d = run ? ST_WAIT_TICK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    hs_enter = is_step(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      fault_q    <= 1'b0;
      level_q    <= '0;
      ball_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      fault_q    <= fault_d;
      level_q    <= level_d;
      ball_cnt_q <= ball_cnt_d;
    end
  end

  always_comb begin
    paddle_step  = hs_step && (state_q == ST_PADDLE);
    ball_step    = hs_step && (state_q == ST_BALL);
    collide_step = hs_step && (state_q == ST_COLLIDE);
    frame_done   = (state_q == ST_FRAME_END);
    level        = level_q;
    overrun      = overrun_q;
    fault        = fault_q;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Frame sequencer for the game update pipeline. It consumes the one-cycle tick pulse from the game timer and runs one update frame per accepted tick. Each frame steps the paddle, then the ball, then collision resolution, using a strobe/done handshake with each engine. Ball speed scales with a saturating level register driven by gameplay events.

Parameters:
BALL_DIV0, 8, ticks per ball step at level 0 (≥1)
MAX_LEVEL, 7, highest speed level; the divisor at level L is max(BALL_DIV0 - L, 1)
TIMEOUT, 1023, cycles to wait for a done before forcing the phase to complete
LVL_W, 3, width of the level port (must hold MAX_LEVEL)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle pulse from the game timer
run  in  1  game active; low parks the block in IDLE
pause  in  1  ignore ticks while high
speed_up  in  1  pulse, level+1, saturating
speed_reset  in  1  pulse, level←0 (life lost / new game)
paddle_step  out  1  one-cycle strobe to the paddle engine
paddle_done  in  1  one-cycle completion from the paddle engine
ball_step  out  1  one-cycle strobe to the ball engine
ball_done  in  1  one-cycle completion from the ball engine
collide_step  out  1  one-cycle strobe to the collision engine
collide_done  in  1  one-cycle completion from the collision engine
frame_done  out  1  one-cycle pulse at the end of each frame
level  out  LVL_W  current speed level
overrun  out  1  sticky: a tick arrived while one was already pending
fault  out  1  sticky: a handshake timed out

Behaviour:
- Reset: state=IDLE; all strobes, frame_done, overrun and fault at 0; level=0; ball_cnt=0; pending=0; timeout counter=0. Reset mid-frame aborts the frame with no further strobes.
- States: IDLE, WAIT_TICK, PADDLE, BALL, COLLIDE, FRAME_END.
- IDLE → WAIT_TICK when run=1. Any state → IDLE at FRAME_END or in WAIT_TICK when run=0. A frame in progress always completes.
- WAIT_TICK: a tick with pause=0 (or pending=1 with pause=0) starts a frame. Clear pending, then go to PADDLE. The tick in cycle N produces paddle_step in cycle N+1.
- In each step state, the strobe is high only on the first cycle of the state, then the block waits for the matching done.
  - A done in cycle M produces the next strobe in cycle M+1.
  - A done arriving in the same cycle as the strobe is accepted.
  - Done inputs outside their own phase are ignored.
- PADDLE → BALL if ball_cnt == div-1, with ball_cnt←0. Otherwise ball_cnt←ball_cnt+1 and go to FRAME_END, skipping the ball and collision phases.
- BALL → COLLIDE → FRAME_END.
- div is computed from the level in the cycle the PADDLE phase ends. If div drops below ball_cnt+1, the step fires and ball_cnt clears, so the counter never runs past the divisor.
- FRAME_END: frame_done=1 for one cycle, then go to WAIT_TICK.
- Timeout: the counter clears on entering each step state. If it reaches TIMEOUT without a done, set fault and advance as if done had arrived.
- Ticks outside WAIT_TICK with pause=0 set pending. If pending is already 1, set overrun. Only one tick is ever queued. With pause=1, ticks are dropped and neither flag changes.
- Level updates any cycle:
  - speed_reset wins over speed_up when both are high.
  - speed_up at MAX_LEVEL holds the level.
  - speed_reset does not clear ball_cnt.
- overrun and fault clear only on reset.

Decomposition:
- Shared game package: state encoding enum, LVL_W, and the default MAX_LEVEL and BALL_DIV0 constants.
- One natural sub-module, phase_handshake: it generates the strobe and runs the done/timeout counter. Instantiate it once and multiplex it by state.

Test Plan:
- run=1, BALL_DIV0=2, level 0, engines answer done 3 cycles after each strobe; tick at cycle 10 → paddle_step at 11. Frame 1 skips the ball phase, frame_done at 15. Frame 2 runs paddle, ball and collide strobes in order, then frame_done. fault=0.
- Second tick during BALL → pending=1, and the next frame starts the cycle after FRAME_END→WAIT_TICK. A third tick before that frame starts → overrun=1 and stays 1.
- speed_up ×9 with MAX_LEVEL=7 → level=7. speed_up and speed_reset in the same cycle → level=0. BALL_DIV0=8 at level 7 → ball step every tick.
- Ball engine never answers → exactly TIMEOUT cycles after ball_step, fault=1, collide_step on the next cycle, frame_done follows.
- pause=1 with 3 ticks → no strobes, pending=0. pause=0 with the next tick → normal frame.
- Reset asserted while in COLLIDE → next cycle state IDLE, level=0, flags=0, and no collide_step reissued after reset falls until run=1 and a tick arrive.
